strobe_arbiter: RTL and testbench



---
 rtl/strobe_arbiter_pkg.sv | 21 ++
 rtl/strobe_arbiter_rr_pick.sv | 34 +++
 rtl/strobe_arbiter.sv | 147 ++++++++++++++
 tb/tb_strobe_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_arbiter_pkg.sv
// strobe_arbiter_pkg: state encodings and width helper shared by the strobe
// arbiter and its rotating priority encoder.
`default_nettype none

package strobe_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GUARD    = 2'd3
   } state_t;

   // Index/counter width that never collapses to zero bits.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/strobe_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder; returns the first set
// request at or above i_ptr, wrapping modulo NUM_REQ.
`default_nettype none

module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [IDW-1:0]     o_idx,
   output logic               o_found
);

   int w_pos;

   // Scan from the far end of the rotation down to ptr so the nearest
   // candidate is the last one written.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_pos   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = (int'(i_ptr) + k) % NUM_REQ;
         if (i_req[w_pos]) begin
            o_idx   = IDW'(w_pos);
            o_found = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/strobe_arbiter.sv
// strobe_arbiter: round-robin arbiter feeding one strobe CDC channel with a
// guard interval; optional return-ack mode via STROBE_ARBITER_ACK_EN.
`default_nettype none

module strobe_arbiter
   import strobe_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int GAP         = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]        req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            strobe_out,
   output logic [WIDTH-1:0]                data_out,
   output logic [id_width(NUM_REQ)-1:0]    src_id,
   input  logic                            ack_in,
   output logic                            timeout_err,
   output logic                            busy
);

   localparam int IDW = id_width(NUM_REQ);
   localparam int GW  = id_width(GAP + 1);

   state_t               r_state;
   state_t               w_next;
   state_t               w_post;
   logic [IDW-1:0]       r_ptr;
   logic [IDW-1:0]       r_src_id;
   logic [IDW-1:0]       w_win;
   logic                 w_found;
   logic                 w_grant;
   logic [WIDTH-1:0]     r_data;
   logic                 r_strobe;
   logic [NUM_REQ-1:0]   r_ready;
   logic                 r_busy;
   logic [GW-1:0]        r_gcnt;
   logic                 w_timeout;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_idx   (w_win),
      .o_found (w_found)
   );

   assign w_grant = (r_state == ST_IDLE) && w_found;
   assign w_post  = (GAP == 0) ? ST_IDLE : ST_GUARD;

`ifdef STROBE_ARBITER_ACK_EN
   localparam int TW = id_width(ACK_TIMEOUT + 1);

   logic [TW-1:0] r_tcnt;

   // r_tcnt holds the 1-based index of the current WAIT_ACK cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcnt <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_tcnt <= TW'(1);
      end else if (r_state == ST_WAIT_ACK) begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end
`else
   logic w_unused_ack;
   assign w_unused_ack = ack_in | (ACK_TIMEOUT == 0);
`endif

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
`ifdef STROBE_ARBITER_ACK_EN
            w_next = ST_WAIT_ACK;
`else
            w_next = w_post;
`endif
         end
`ifdef STROBE_ARBITER_ACK_EN
         ST_WAIT_ACK: begin
            if (ack_in) begin
               w_next = w_post;
            end else if (r_tcnt == TW'(ACK_TIMEOUT)) begin
               w_timeout = 1'b1;
               w_next    = w_post;
            end
         end
`endif
         ST_GUARD: begin
            if (r_gcnt == GW'(1)) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_src_id <= '0;
         r_data   <= '0;
         r_strobe <= 1'b0;
         r_ready  <= '0;
         r_busy   <= 1'b0;
         r_gcnt   <= '0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next != ST_IDLE);
         r_strobe <= w_grant;
         r_ready  <= '0;
         if (w_grant) begin
            r_ready  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
            r_data   <= req_data[w_win*WIDTH +: WIDTH];
            r_src_id <= w_win;
            r_ptr    <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
         end
         // Guard counter loads GAP on entry and leaves GUARD when it reaches 1.
         if ((w_next == ST_GUARD) && (r_state != ST_GUARD)) begin
            r_gcnt <= GW'(GAP);
         end else if (r_state == ST_GUARD) begin
            r_gcnt <= r_gcnt - 1'b1;
         end
      end
   end

   assign req_ready   = r_ready;
   assign strobe_out  = r_strobe;
   assign data_out    = r_data;
   assign src_id      = r_src_id;
   assign busy        = r_busy;
   assign timeout_err = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_strobe_arbiter.sv
// tb_strobe_arbiter: directed self-checking bench for strobe_arbiter
// (GAP=4 main instance plus a GAP=0 instance).
`default_nettype none

module tb_strobe_arbiter;

   localparam int GAP   = 4;
   localparam int ACK_T = 10;
`ifdef STROBE_ARBITER_ACK_EN
   localparam int RR_SPACING = ACK_T + GAP + 2;
   localparam int BUSY_LEN   = 1 + ACK_T + GAP;
   localparam int Z_SPACING  = ACK_T + 2;
`else
   localparam int RR_SPACING = GAP + 2;
   localparam int BUSY_LEN   = 1 + GAP;
   localparam int Z_SPACING  = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid, req_ready, z_req_valid, z_req_ready;
   logic [31:0] req_data, z_req_data;
   logic        strobe_out, z_strobe_out;
   logic [7:0]  data_out, z_data_out;
   logic [1:0]  src_id, z_src_id;
   logic        ack_in, timeout_err, busy, z_ack_in, z_timeout_err, z_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   strobe_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP(GAP), .ACK_TIMEOUT(ACK_T)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .strobe_out(strobe_out), .data_out(data_out),
      .src_id(src_id), .ack_in(ack_in), .timeout_err(timeout_err), .busy(busy)
   );

   strobe_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP(0), .ACK_TIMEOUT(ACK_T)) dut0 (
      .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_data(z_req_data),
      .req_ready(z_req_ready), .strobe_out(z_strobe_out), .data_out(z_data_out),
      .src_id(z_src_id), .ack_in(z_ack_in), .timeout_err(z_timeout_err), .busy(z_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin step(); n++; end while (strobe_out !== 1'b1 && n < 40);
      checks++;
      if (strobe_out !== 1'b1) begin errors++; $display("FAIL strobe_wait: strobe_out=%b expected 1 within 40 cycles", strobe_out); end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin step(); n++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy=%b expected 0", busy); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks += 6;
      if (strobe_out !== 1'b0)  begin errors++; $display("FAIL rst_strobe: got %b exp 0", strobe_out); end
      if (req_ready !== 4'h0)   begin errors++; $display("FAIL rst_ready: got %b exp 0000", req_ready); end
      if (data_out !== 8'h00)   begin errors++; $display("FAIL rst_data: got %h exp 00", data_out); end
      if (src_id !== 2'd0)      begin errors++; $display("FAIL rst_src: got %0d exp 0", src_id); end
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", timeout_err); end
      if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      int last = 0;
      logic [1:0] exp_id;
      req_data  = 32'h13121110;
      req_valid = 4'hF;
      for (int g = 0; g < 5; g++) begin
         wait_strobe();
         exp_id = 2'(g % 4);
         checks += 3;
         if (src_id !== exp_id) begin errors++; $display("FAIL rr_src[%0d]: got %0d exp %0d", g, src_id, exp_id); end
         if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_ready[%0d]: got %b exp %b", g, req_ready, 4'b0001 << exp_id); end
         if (data_out !== (8'h10 + {6'd0, exp_id})) begin errors++; $display("FAIL rr_data[%0d]: got %h exp %h", g, data_out, 8'h10 + {6'd0, exp_id}); end
         if (g > 0) begin
            checks++;
            if (cyc - last != RR_SPACING) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d exp %0d", g, cyc - last, RR_SPACING); end
         end
         last = cyc;
      end
      req_valid = 4'h0;
      wait_idle();
   endtask

   task automatic test_single();
      int n = 1;
      req_data  = 32'h0000A500;
      req_valid = 4'b0010;
      step();
      checks += 5;
      if (strobe_out !== 1'b1)  begin errors++; $display("FAIL single_strobe: got %b exp 1", strobe_out); end
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b exp 0010", req_ready); end
      if (data_out !== 8'hA5)   begin errors++; $display("FAIL single_data: got %h exp a5", data_out); end
      if (src_id !== 2'd1)      begin errors++; $display("FAIL single_src: got %0d exp 1", src_id); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
      req_valid = 4'h0;
      step();
      while (busy === 1'b1 && n < 40) begin n++; step(); end
      checks += 3;
      if (n != BUSY_LEN)      begin errors++; $display("FAIL single_busy_len: got %0d exp %0d", n, BUSY_LEN); end
      if (strobe_out !== 1'b0) begin errors++; $display("FAIL single_strobe_low: got %b exp 0", strobe_out); end
      if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h exp a5", data_out); end
   endtask

   task automatic test_reset_in_guard();
      req_data  = 32'h005C0000;
      req_valid = 4'b0100;
      step();
      checks++;
      if (src_id !== 2'd2) begin errors++; $display("FAIL rg_grant: got %0d exp 2", src_id); end
      req_valid = 4'h0;
      step(); step();
      reset = 1'b1;
      step();
      checks += 5;
      if (strobe_out !== 1'b0) begin errors++; $display("FAIL rg_strobe: got %b exp 0", strobe_out); end
      if (req_ready !== 4'h0)  begin errors++; $display("FAIL rg_ready: got %b exp 0000", req_ready); end
      if (data_out !== 8'h00)  begin errors++; $display("FAIL rg_data: got %h exp 00", data_out); end
      if (src_id !== 2'd0)     begin errors++; $display("FAIL rg_src: got %0d exp 0", src_id); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL rg_busy: got %b exp 0", busy); end
      reset     = 1'b0;
      req_data  = 32'h44332211;
      req_valid = 4'hF;
      step();
      checks += 3;
      if (src_id !== 2'd0)       begin errors++; $display("FAIL rg_next_src: got %0d exp 0", src_id); end
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL rg_next_ready: got %b exp 0001", req_ready); end
      if (data_out !== 8'h11)    begin errors++; $display("FAIL rg_next_data: got %h exp 11", data_out); end
      req_valid = 4'h0;
      wait_idle();
   endtask

   task automatic test_gap0();
      int last = 0;
      int n;
      logic [1:0] exp_id;
      z_req_data  = 32'h0000B1B0;
      z_req_valid = 4'b0011;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         do begin step(); n++; end while (z_strobe_out !== 1'b1 && n < 40);
         exp_id = 2'(g % 2);
         checks += 3;
         if (z_strobe_out !== 1'b1) begin errors++; $display("FAIL g0_strobe[%0d]: got %b exp 1", g, z_strobe_out); end
         if (z_src_id !== exp_id)   begin errors++; $display("FAIL g0_src[%0d]: got %0d exp %0d", g, z_src_id, exp_id); end
         if (z_data_out !== (8'hB0 + {6'd0, exp_id})) begin errors++; $display("FAIL g0_data[%0d]: got %h exp %h", g, z_data_out, 8'hB0 + {6'd0, exp_id}); end
         if (g > 0) begin
            checks++;
            if (cyc - last != Z_SPACING) begin errors++; $display("FAIL g0_spacing[%0d]: got %0d exp %0d", g, cyc - last, Z_SPACING); end
         end
         last = cyc;
      end
      z_req_valid = 4'h0;
      n = 0;
      while (z_busy !== 1'b0 && n < 40) begin step(); n++; end
      checks++;
      if (z_busy !== 1'b0) begin errors++; $display("FAIL g0_idle: busy=%b exp 0", z_busy); end
   endtask

`ifdef STROBE_ARBITER_ACK_EN
   task automatic test_ack();
      int c0;
      int n = 0;
      req_data  = 32'h0000C1C0;
      req_valid = 4'b0011;
      wait_strobe();
      c0 = cyc;
      ack_in = 1'b1; step(); ack_in = 1'b0;   // ack during ISSUE is ignored
      step(); step();
      ack_in = 1'b1; step(); ack_in = 1'b0;   // accepted on the 3rd WAIT_ACK cycle
      step();
      ack_in = 1'b1; step(); ack_in = 1'b0;   // lands in GUARD, ignored
      wait_strobe();
      checks++;
      if (cyc - c0 != 3 + GAP + 2) begin errors++; $display("FAIL ack_spacing: got %0d exp %0d", cyc - c0, 3 + GAP + 2); end
      c0 = cyc;
      while (timeout_err !== 1'b1 && n < 40) begin step(); n++; end
      checks++;
      if (cyc - c0 != ACK_T) begin errors++; $display("FAIL ack_timeout_at: got %0d exp %0d", cyc - c0, ACK_T); end
      step();
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack_timeout_pulse: got %b exp 0", timeout_err); end
      wait_strobe();
      checks++;
      if (cyc - c0 != ACK_T + GAP + 2) begin errors++; $display("FAIL ack_timeout_spacing: got %0d exp %0d", cyc - c0, ACK_T + GAP + 2); end
      req_valid = 4'h0;
      wait_idle();
   endtask
`endif

   initial begin
      reset       = 1'b1;
      req_valid   = 4'h0;
      req_data    = 32'h0;
      ack_in      = 1'b0;
      z_req_valid = 4'h0;
      z_req_data  = 32'h0;
      z_ack_in    = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_reset_in_guard();
      test_gap0();
`ifdef STROBE_ARBITER_ACK_EN
      test_ack();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
